// File: rtl/iter_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: state encoding
// and default iteration parameters.
package iter_seq_pkg;

  localparam int ITERS_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: synchronous clear has priority over enable; asynchronous
// active-low reset.
module iter_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/iter_seq_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: one operand-load cycle,
// ITERS step cycles, then a one-cycle result strobe. Define ITER_SEQ_OPCOUNT_EN
// to build the completed-operation counter on op_count.
module iter_seq_ctrl
  import iter_seq_pkg::*;
#(
  parameter int ITERS = ITERS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             div_by_zero,
  output logic             dp_init,
  output logic             dp_step,
  output logic             dp_is_div,
  output logic [CNT_W-1:0] iter_idx,
  output logic             busy,
  output logic             result_ready,
  output logic             exception,
  output logic [31:0]      op_count,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERS - 1);

  // Requests are single-cycle pulses with no ready: a pulse sampled in any state
  // (including busy ones) is always accepted and restarts the sequence in INIT.
  logic             req;
  state_e           state_q, state_d;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             exc_q, exc_d;

  assign req = start_mult | start_div;

  iter_counter #(.W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    exc_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_INIT;
      end
      ST_INIT: begin
        cnt_clr = 1'b1;
        if (req) begin
          state_d = ST_INIT;
        end else if (is_div_q && div_by_zero) begin
          state_d = ST_DONE;
          exc_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req) begin
          state_d = ST_INIT;
        end else if (cnt == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = req ? ST_INIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      // Multiply wins when both requests arrive together.
      if (req) is_div_q <= start_div & ~start_mult;
    end
  end

  assign dp_init      = (state_q == ST_INIT);
  assign dp_step      = (state_q == ST_RUN);
  assign busy         = (state_q != ST_IDLE);
  assign result_ready = (state_q == ST_DONE);
  assign dp_is_div    = is_div_q;
  assign exception    = exc_q;
  assign iter_idx     = dp_step ? cnt : '0;
  assign dbg_state    = state_q;

`ifdef ITER_SEQ_OPCOUNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count_q <= 32'd0;
    end else if (state_q == ST_DONE) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Testbench for iter_seq_ctrl: directed scenarios plus random request pulses,
// checked every cycle against a timeline model of the operation.
module tb_iter_seq_ctrl;
  import iter_seq_pkg::*;

  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start_mult = 1'b0;
  logic             start_div = 1'b0;
  logic             div_by_zero = 1'b0;
  logic             dp_init, dp_step, dp_is_div, busy, result_ready, exception;
  logic [CNT_W-1:0] iter_idx;
  logic [31:0]      op_count;
  logic [1:0]       dbg_state;

  iter_seq_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .div_by_zero  (div_by_zero),
    .dp_init      (dp_init),
    .dp_step      (dp_step),
    .dp_is_div    (dp_is_div),
    .iter_idx     (iter_idx),
    .busy         (busy),
    .result_ready (result_ready),
    .exception    (exception),
    .op_count     (op_count),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard of expected result records {is_div, exception}
  logic [31:0] exp_q[$];

  // Timeline model: m_t counts cycles since the request was accepted
  // (0 = operand load); m_short marks the divide-by-zero shortcut.
  bit          m_active = 0;
  bit          m_div = 0;
  bit          m_short = 0;
  int          m_t = 0;
  logic [31:0] m_ops = 32'd0;

  function automatic bit m_init();
    return m_active && (m_t == 0);
  endfunction

  function automatic bit m_step();
    return m_active && !m_short && (m_t >= 1) && (m_t <= ITERS);
  endfunction

  function automatic bit m_done();
    return m_active && (m_short ? (m_t == 1) : (m_t == ITERS + 1));
  endfunction

  task automatic model_clear();
    m_active = 0;
    m_div    = 0;
    m_short  = 0;
    m_t      = 0;
    m_ops    = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_update(input bit mult, input bit div, input bit dbz);
    bit d;
    d = m_done();
`ifdef ITER_SEQ_OPCOUNT_EN
    if (d) m_ops = m_ops + 32'd1;
`endif
    if (mult || div) begin
      m_active = 1;
      m_t      = 0;
      m_div    = div && !mult;
      m_short  = 0;
    end else if (m_active) begin
      if (d) begin
        m_active = 0;
      end else begin
        if (m_t == 0 && m_div && dbz) m_short = 1;
        m_t++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0]       st;
    logic [CNT_W-1:0] idx;
    logic [13:0]      expv, obs;
    logic [31:0]      rec;
    if (!m_active)    st = ST_IDLE;
    else if (m_init()) st = ST_INIT;
    else if (m_done()) st = ST_DONE;
    else              st = ST_RUN;
    idx  = m_step() ? CNT_W'(m_t - 1) : '0;
    expv = {st, m_init(), m_step(), m_div, idx, m_active, m_done(), m_done() && m_short};
    obs  = {dbg_state, dp_init, dp_step, dp_is_div, iter_idx, busy, result_ready, exception};
    check(tag, 32'(obs), 32'(expv));
    check({tag, "_opcount"}, op_count, m_ops);
    if (m_done()) exp_q.push_back({30'd0, m_div, m_short});
    if (result_ready) begin
      rec = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
      check({tag, "_result"}, {30'd0, dp_is_div, exception}, rec);
    end
  endtask

  // Driver tasks
  task automatic step(input bit mult, input bit div, input bit dbz, input string tag);
    @(negedge clk);
    start_mult  = mult;
    start_div   = div;
    div_by_zero = dbz;
    @(posedge clk);
    model_update(mult, div, dbz);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, tag);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset       = 1'b0;
    start_mult  = 1'b0;
    start_div   = 1'b0;
    div_by_zero = 1'b0;
    model_clear();
    #1;
    check_outputs("in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    apply_reset();
    idle(10, "reset_idle");

    // Plain multiply: full ITERS-step sequence
    step(1, 0, 0, "mult_req");
    idle(ITERS + 3, "mult_run");

    // Divide by zero: flag high during the operand-load cycle
    step(0, 1, 0, "dbz_req");
    step(0, 0, 1, "dbz_init");
    idle(3, "dbz_after");

    // Divide with a valid divisor
    step(0, 1, 0, "div_req");
    step(0, 0, 0, "div_init");
    idle(ITERS + 2, "div_run");

    // Divide request while multiply is at iter_idx 10
    step(1, 0, 0, "abort_mult");
    idle(11, "abort_pre");
    step(0, 1, 0, "abort_div");
    idle(ITERS + 3, "abort_run");

    // Both requests together: multiply wins
    step(1, 1, 0, "both_req");
    idle(ITERS + 3, "both_run");

    // Back-to-back: new divide sampled in DONE, then divide by zero
    step(1, 0, 0, "b2b_mult");
    idle(ITERS + 1, "b2b_run");
    step(0, 1, 0, "b2b_div");
    step(0, 0, 1, "b2b_init");
    idle(3, "b2b_after");

    // Restart while in the operand-load cycle
    step(1, 0, 0, "init_abort1");
    step(0, 1, 0, "init_abort2");
    step(0, 0, 0, "init_abort3");
    idle(ITERS + 3, "init_abort_run");

    // Reset during RUN
    step(1, 0, 0, "rst_mid_req");
    idle(6, "rst_mid_run");
    apply_reset();
    idle(5, "rst_mid_after");
`ifdef ITER_SEQ_OPCOUNT_EN
    check("opcount_after_reset", op_count, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, "three_ops_req");
      idle(ITERS + 2, "three_ops_run");
    end
`ifdef ITER_SEQ_OPCOUNT_EN
    check("opcount_three", op_count, 32'd3);
`endif

    // Random request pulses
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 24);
      step(r == 0 || r == 3, r == 1 || r == 2 || r == 3, 1'($urandom_range(0, 1)), "random");
    end
    idle(ITERS + 3, "drain");
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
